fft_frame_ctrl: RTL and testbench
=================================

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 SHALL have parameter N, default 32, FFT points per frame.
REQ-002 SHALL have parameter WIDTH, default 16, bits per FFT point (Q8.8).
REQ-003 SHALL have parameter ADC_W, default 8, bits per ADC sample (signed Q4.4).
REQ-004 SHALL have parameter FFT_LAT, default 6 ($clog2(N)+1), cycles from FFT input sample to FFT output.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port adc_valid  in  1  sample offered.
REQ-008 SHALL have port adc_data  in  ADC_W  signed Q4.4 sample.
REQ-009 SHALL have port adc_ready  out  1  sample accepted when adc_valid && adc_ready.
REQ-010 SHALL have port flush  in  1  synchronous discard of partial/unissued frame.
REQ-011 SHALL have port fft_start  out  1  one-cycle issue strobe to FFT.
REQ-012 SHALL have port data_in  out  N*WIDTH  packed frame to FFT, point k at [(N-k)*WIDTH-1 -: WIDTH].
REQ-013 SHALL have port data_out_real  in  N*WIDTH  FFT real result, same packing.
REQ-014 SHALL have port data_out_imag  in  N*WIDTH  FFT imaginary result, same packing.
REQ-015 SHALL have port res_real  out  N*WIDTH  captured real result.
REQ-016 SHALL have port res_imag  out  N*WIDTH  captured imaginary result.
REQ-017 SHALL have port res_valid  out  1  result held; consumed when res_valid && res_ready.
REQ-018 SHALL have port res_ready  in  1  downstream accepts result.
REQ-019 SHALL have port busy  out  1  high in any FSM state other than IDLE.

Function
REQ-020 Each accepted sample SHALL be widened Q4.4->Q8.8 as {4 x sign, sample, 4'b0000} and written to point index = sample counter; counter 0..N-1, first sample after reset/flush/issue is index 0.
REQ-021 Acceptance of sample N-1 SHALL set frame_full and wrap counter to 0; adc_ready = !frame_full.
REQ-022 FSM states IDLE, RUN, HOLD; IDLE->RUN when frame_full, that cycle's registered outputs give fft_start=1 for exactly one cycle with data_in = frame, frame_full cleared.
REQ-023 data_in SHALL remain stable at the issued frame until next issue; fft_start SHALL be 0 outside the issue cycle.
REQ-024 RUN: latency counter counts FFT_LAT cycles after the fft_start cycle; in cycle (issue+FFT_LAT) data_out_real/imag SHALL be captured into res_real/res_imag, res_valid=1 from next cycle, state->HOLD.
REQ-025 HOLD: res_real/res_imag/res_valid held stable until res_valid && res_ready; then res_valid=0, state->IDLE same edge.
REQ-026 Sample filling SHALL continue during RUN and HOLD; a next full frame waits in buffer (adc_ready=0) until IDLE.
REQ-027 IDLE with frame_full on the cycle after a HOLD handshake SHALL issue immediately (no bubble beyond that one IDLE cycle).
REQ-028 flush=1 SHALL clear sample counter and frame_full next edge and drop any sample offered that cycle; flush SHALL NOT affect RUN/HOLD or results.
REQ-029 flush and issue in the same cycle: issue wins, flush only clears counter.
REQ-030 No arithmetic saturation; widening is lossless.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE, counters 0, frame_full 0, fft_start 0, data_in 0, res_real 0, res_imag 0, res_valid 0, busy 0, adc_ready 1 (combinational from frame_full).
REQ-032 Reset mid-RUN/HOLD SHALL discard in-flight result; no res_valid after release until a new frame completes.

Structure
REQ-033 Package fft_pkg SHALL hold N, WIDTH, ADC_W, FFT_LAT defaults and the FSM state enum.
REQ-034 Serial-to-parallel buffer (counter, widening, frame_full, flush) SHALL be sub-module fft_sample_packer; FSM, latency counter, result capture in fft_frame_ctrl; FFT itself instantiated by integration top, not here.

Verification
REQ-035 Reset: rst_n low 3 cycles -> all outputs 0, adc_ready=1; assert rst_n async mid-cycle -> outputs 0 immediately.
REQ-036 32 samples 0x10 (1.0) back-to-back -> fft_start pulse 1 cycle, every data_in point 0x0100; bench FFT model returns bin0 real 0x2000 -> res_valid exactly 7 cycles after fft_start, res_real point0=0x2000.
REQ-037 Sample 0x80 (-8.0) -> data_in point 0xF800; sample 0x7F -> 0x07F0.
REQ-038 res_ready held 0 for 100 cycles while 64 samples offered -> 32 accepted, adc_ready=0 after, res_* stable; res_ready=1 -> second frame issued 2 cycles later.
REQ-039 flush after 17 samples -> next 32 samples form frame with first post-flush sample at point 0; flush during RUN -> result unaffected.
REQ-040 rst_n low 3 cycles into RUN -> no res_valid; new 32-sample frame completes normally.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared defaults and types for the FFT frame controller slice.
//   N_DEF       : FFT points per frame
//   WIDTH_DEF   : bits per FFT point (Q8.8)
//   ADC_W_DEF   : bits per ADC sample (signed Q4.4)
//   FFT_LAT_DEF : cycles from FFT input sample to FFT output
//   state_t     : frame controller FSM states
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int N_DEF       = 32;
    localparam int WIDTH_DEF   = 16;
    localparam int ADC_W_DEF   = 8;
    localparam int FFT_LAT_DEF = $clog2(N_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fft_sample_packer.sv
// -----------------------------------------------------------------------------
// fft_sample_packer
// Serial-to-parallel frame buffer. Each accepted ADC sample is widened from
// signed Q4.4 to Q8.8 and stored at the current point index. Acceptance of the
// last point raises frame_full, which blocks further samples until the frame
// is issued (issue) or discarded (flush).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   adc_valid    : sample offered
//   adc_data     : signed Q4.4 sample
//   adc_ready    : sample accepted when adc_valid && adc_ready
//   flush        : discard partial/unissued frame, drop this cycle's sample
//   issue        : frame handed to the FFT this cycle, clear frame_full
//   frame_full   : all N points of the buffer are valid
//   frame        : packed buffer, point k at [(N-k)*WIDTH-1 -: WIDTH]
// -----------------------------------------------------------------------------
module fft_sample_packer
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adc_valid,
    input  logic [ADC_W-1:0]     adc_data,
    output logic                 adc_ready,
    input  logic                 flush,
    input  logic                 issue,
    output logic                 frame_full,
    output logic [N*WIDTH-1:0]   frame
);

    localparam int CNT_W    = (N > 1) ? $clog2(N) : 1;
    // Q4.4 -> Q8.8: half the extra bits extend the sign, half pad the fraction.
    localparam int SIGN_EXT = (WIDTH - ADC_W) / 2;
    localparam int FRAC_PAD = WIDTH - ADC_W - SIGN_EXT;

    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_point;
    logic [WIDTH-1:0] widened;
    logic [WIDTH-1:0] points [N];

    assign adc_ready  = !frame_full;
    assign accept     = adc_valid && adc_ready && !flush;
    assign last_point = (cnt == CNT_W'(N - 1));
    assign widened    = {{SIGN_EXT{adc_data[ADC_W-1]}}, adc_data, {FRAC_PAD{1'b0}}};

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_full <= 1'b0;
        end else begin
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                cnt <= last_point ? '0 : cnt + CNT_W'(1);
            end

            // Issue only happens while full, so it can never coincide with the
            // acceptance of the last point.
            if (issue || flush) begin
                frame_full <= 1'b0;
            end else if (accept && last_point) begin
                frame_full <= 1'b1;
            end
        end
    end

    // NOTE: the point storage has no reset; frame_full gates its use and every
    // point is rewritten before a frame can become full again.
    always_ff @(posedge clk) begin
        if (accept) begin
            points[cnt] <= widened;
        end
    end

    always_comb begin
        frame = '0;
        for (int k = 0; k < N; k++) begin
            frame[(N-k)*WIDTH-1 -: WIDTH] = points[k];
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// fft_frame_ctrl
// Collects ADC samples into N-point frames, issues each full frame to an
// external FFT with a one-cycle fft_start strobe, waits FFT_LAT cycles, then
// captures and holds the FFT result until the downstream handshake.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   adc_valid, adc_data, adc_ready: sample input handshake (signed Q4.4)
//   flush                         : discard partial/unissued frame
//   fft_start                     : one-cycle issue strobe to the FFT
//   data_in                       : packed frame to the FFT (Q8.8 points)
//   data_out_real, data_out_imag  : FFT result, same packing as data_in
//   res_real, res_imag            : captured result
//   res_valid, res_ready          : result output handshake
//   busy                          : FSM is not in IDLE
// -----------------------------------------------------------------------------
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int ADC_W   = ADC_W_DEF,
    parameter int FFT_LAT = FFT_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adc_valid,
    input  logic [ADC_W-1:0]     adc_data,
    output logic                 adc_ready,
    input  logic                 flush,
    output logic                 fft_start,
    output logic [N*WIDTH-1:0]   data_in,
    input  logic [N*WIDTH-1:0]   data_out_real,
    input  logic [N*WIDTH-1:0]   data_out_imag,
    output logic [N*WIDTH-1:0]   res_real,
    output logic [N*WIDTH-1:0]   res_imag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    localparam int LAT_W = $clog2(FFT_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic               issue;
    logic               capture;
    logic               release_res;
    logic               frame_full;
    logic [N*WIDTH-1:0] frame;
    logic [LAT_W-1:0]   lat_cnt;

    fft_sample_packer #(
        .N     (N),
        .WIDTH (WIDTH),
        .ADC_W (ADC_W)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .adc_ready  (adc_ready),
        .flush      (flush),
        .issue      (issue),
        .frame_full (frame_full),
        .frame      (frame)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        issue       = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            IDLE: begin
                if (frame_full) begin
                    issue     = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                // lat_cnt is 0 in the fft_start cycle, so it reaches FFT_LAT
                // exactly when the FFT presents this frame's result.
                if (lat_cnt == LAT_W'(FFT_LAT)) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // res_valid is always set while in HOLD.
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt   <= '0;
            fft_start <= 1'b0;
            data_in   <= '0;
            res_real  <= '0;
            res_imag  <= '0;
            res_valid <= 1'b0;
        end else begin
            fft_start <= issue;

            if (issue) begin
                lat_cnt <= '0;
                data_in <= frame;
            end else if (state == RUN) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end

            if (capture) begin
                res_real  <= data_out_real;
                res_imag  <= data_out_imag;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_frame_ctrl
// Self-checking bench for fft_frame_ctrl. A behavioural FFT stand-in presents
// its result only in the cycle FFT_LAT after fft_start. Expected frames are
// queued as samples are accepted and compared at fft_start; expected results
// are queued at fft_start and compared when res_valid rises.
// -----------------------------------------------------------------------------
module tb_fft_frame_ctrl;
    import fft_pkg::*;

    localparam int N       = 32;
    localparam int WIDTH   = 16;
    localparam int ADC_W   = 8;
    localparam int FFT_LAT = 6;
    localparam int FW      = N * WIDTH;

    logic               clk;
    logic               rst_n;
    logic               adc_valid;
    logic [ADC_W-1:0]   adc_data;
    logic               adc_ready;
    logic               flush;
    logic               fft_start;
    logic [FW-1:0]      data_in;
    logic [FW-1:0]      data_out_real;
    logic [FW-1:0]      data_out_imag;
    logic [FW-1:0]      res_real;
    logic [FW-1:0]      res_imag;
    logic               res_valid;
    logic               res_ready;
    logic               busy;

    fft_frame_ctrl #(
        .N       (N),
        .WIDTH   (WIDTH),
        .ADC_W   (ADC_W),
        .FFT_LAT (FFT_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .adc_ready     (adc_ready),
        .flush         (flush),
        .fft_start     (fft_start),
        .data_in       (data_in),
        .data_out_real (data_out_real),
        .data_out_imag (data_out_imag),
        .res_real      (res_real),
        .res_imag      (res_imag),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int n_res  = 0;
    int start_cyc = 0;
    int tb_idx = 0;
    int accepted = 0;

    logic [FW-1:0]    exp_frames [$];
    logic [FW-1:0]    exp_real_q [$];
    logic [FW-1:0]    exp_imag_q [$];
    logic [WIDTH-1:0] exp_pts [N];
    logic [FW-1:0]    held_real;
    logic [FW-1:0]    held_imag;
    logic [FW-1:0]    mon_frame;
    logic             fs_prev = 1'b0;
    logic             rv_prev = 1'b0;

    typedef struct {
        logic [ADC_W-1:0] sample;
        logic [WIDTH-1:0] point;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Q4.4 value times 16 is the same number in Q8.8.
    function automatic logic [WIDTH-1:0] model_widen(input logic [ADC_W-1:0] d);
        logic signed [WIDTH-1:0] t;
        t = $signed(d);
        return t * 16;
    endfunction

    function automatic logic [FW-1:0] pack_pts();
        logic [FW-1:0] f;
        for (int k = 0; k < N; k++) f[(N-k)*WIDTH-1 -: WIDTH] = exp_pts[k];
        return f;
    endfunction

    // FFT stand-in: bin 0 real is the DC sum, other real bins are point+k,
    // imaginary bins are the bitwise inverse of the input points.
    function automatic logic [FW-1:0] model_real(input logic [FW-1:0] f);
        logic [FW-1:0]    r;
        logic [WIDTH-1:0] sum;
        r   = '0;
        sum = '0;
        for (int k = 0; k < N; k++) begin
            sum = sum + f[(N-k)*WIDTH-1 -: WIDTH];
            r[(N-k)*WIDTH-1 -: WIDTH] = f[(N-k)*WIDTH-1 -: WIDTH] + WIDTH'(k);
        end
        r[FW-1 -: WIDTH] = sum;
        return r;
    endfunction

    function automatic logic [FW-1:0] model_imag(input logic [FW-1:0] f);
        return ~f;
    endfunction

    // Result is only meaningful in the cycle FFT_LAT after fft_start.
    logic [FFT_LAT-1:0] start_d;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) start_d <= '0;
        else        start_d <= {start_d[FFT_LAT-2:0], fft_start};
    end
    always_comb begin
        data_out_real = {N{16'hDEAD}};
        data_out_imag = {N{16'hBEEF}};
        if (start_d[FFT_LAT-1]) begin
            data_out_real = model_real(data_in);
            data_out_imag = model_imag(data_in);
        end
    end

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            fs_prev = 1'b0;
            rv_prev = 1'b0;
        end else begin
            if (fft_start) begin
                check("start_width", FW'(fs_prev), FW'(0));
                check("start_has_frame", FW'(exp_frames.size() > 0), FW'(1));
                if (exp_frames.size() > 0) begin
                    mon_frame = exp_frames.pop_front();
                    check("data_in", data_in, mon_frame);
                    exp_real_q.push_back(model_real(mon_frame));
                    exp_imag_q.push_back(model_imag(mon_frame));
                end
                start_cyc = cyc;
            end
            if (res_valid && !rv_prev) begin
                check("res_latency", FW'(cyc - start_cyc), FW'(FFT_LAT + 1));
                check("res_expected", FW'(exp_real_q.size() > 0), FW'(1));
                if (exp_real_q.size() > 0) begin
                    check("res_real", res_real, exp_real_q.pop_front());
                    check("res_imag", res_imag, exp_imag_q.pop_front());
                end
                held_real = res_real;
                held_imag = res_imag;
                n_res++;
            end else if (res_valid) begin
                check("res_hold_real", res_real, held_real);
                check("res_hold_imag", res_imag, held_imag);
            end
            fs_prev = fft_start;
            rv_prev = res_valid;
        end
    end

    // One cycle of stimulus; called just after a rising edge.
    task automatic drive(input logic v, input logic [ADC_W-1:0] d,
                         input logic [WIDTH-1:0] exp_pt, input logic f);
        adc_valid = v;
        adc_data  = d;
        flush     = f;
        @(negedge clk);
        if (f) begin
            tb_idx = 0;
        end else if (v && adc_ready) begin
            accepted++;
            exp_pts[tb_idx] = exp_pt;
            tb_idx++;
            if (tb_idx == N) begin
                exp_frames.push_back(pack_pts());
                tb_idx = 0;
            end
        end
        @(posedge clk);
        #1;
        adc_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic send_random(input int n);
        logic [ADC_W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = ADC_W'($urandom);
            drive(1'b1, d, model_widen(d), 1'b0);
        end
    endtask

    task automatic check_idle(input string pfx);
        check({pfx, "_fft_start"}, FW'(fft_start), FW'(0));
        check({pfx, "_data_in"},   data_in,        FW'(0));
        check({pfx, "_res_real"},  res_real,       FW'(0));
        check({pfx, "_res_imag"},  res_imag,       FW'(0));
        check({pfx, "_res_valid"}, FW'(res_valid), FW'(0));
        check({pfx, "_busy"},      FW'(busy),      FW'(0));
        check({pfx, "_adc_ready"}, FW'(adc_ready), FW'(1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_idle("rst_async");
        exp_frames.delete();
        exp_real_q.delete();
        exp_imag_q.delete();
        tb_idx    = 0;
        adc_valid = 1'b0;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("rst_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_res(input int target);
        int k;
        k = 0;
        while (n_res < target && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("res_timeout", FW'(n_res >= target), FW'(1));
    endtask

    int a0;
    int n0;
    int k;

    initial begin
        vecs[0] = '{sample: 8'h10, point: 16'h0100};
        vecs[1] = '{sample: 8'h80, point: 16'hF800};
        vecs[2] = '{sample: 8'h7F, point: 16'h07F0};
        vecs[3] = '{sample: 8'h00, point: 16'h0000};
        vecs[4] = '{sample: 8'hFF, point: 16'hFFF0};
        vecs[5] = '{sample: 8'h01, point: 16'h0010};
        vecs[6] = '{sample: 8'hF0, point: 16'hFF00};
        vecs[7] = '{sample: 8'h08, point: 16'h0080};

        rst_n     = 1'b1;
        adc_valid = 1'b0;
        adc_data  = '0;
        flush     = 1'b0;
        res_ready = 1'b1;
        #2;
        do_reset();

        // Widening table, cycled across one frame.
        for (int i = 0; i < N; i++) drive(1'b1, vecs[i % 8].sample, vecs[i % 8].point, 1'b0);
        wait_res(1);

        // DC frame of 1.0: bin 0 real must be 32 * 1.0 = 0x2000.
        for (int i = 0; i < N; i++) drive(1'b1, 8'h10, 16'h0100, 1'b0);
        wait_res(2);
        check("dc_bin0_real", FW'(held_real[FW-1 -: WIDTH]), FW'(16'h2000));

        // Random frame with gaps in adc_valid.
        a0 = accepted;
        k  = 0;
        while (accepted - a0 < N && k < 500) begin
            adc_data = ADC_W'($urandom);
            drive(1'($urandom_range(0, 1)), adc_data, model_widen(adc_data), 1'b0);
            k++;
        end
        wait_res(3);

        // Back-pressure: result held, second frame fills and waits.
        res_ready = 1'b0;
        send_random(N);
        wait_res(4);
        a0 = accepted;
        send_random(64);
        check("bp_accepted", FW'(accepted - a0), FW'(N));
        repeat (36) drive(1'b0, '0, '0, 1'b0);
        check("bp_adc_ready", FW'(adc_ready), FW'(0));
        check("bp_res_valid", FW'(res_valid), FW'(1));
        check("bp_busy", FW'(busy), FW'(1));
        res_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("bp_gap_start", FW'(fft_start), FW'(0));
        check("bp_gap_busy", FW'(busy), FW'(0));
        check("bp_gap_valid", FW'(res_valid), FW'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_issue_start", FW'(fft_start), FW'(1));
        @(posedge clk);
        #1;
        wait_res(5);
        check("bp_ready_back", FW'(adc_ready), FW'(1));

        // Flush of a partial frame, with a sample offered in the flush cycle.
        send_random(17);
        drive(1'b1, 8'h55, 16'h0550, 1'b1);
        send_random(N);
        wait_res(6);

        // Flush in the issue cycle and during RUN leaves the result intact.
        send_random(N);
        drive(1'b1, 8'h33, 16'h0330, 1'b1);
        repeat (4) drive(1'b0, '0, '0, 1'b1);
        wait_res(7);

        // Reset three cycles into RUN discards the in-flight result.
        send_random(N);
        k = 0;
        while (!fft_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("run_rst_start_seen", FW'(fft_start), FW'(1));
        @(posedge clk);
        @(posedge clk);
        #3;
        do_reset();
        n0 = n_res;
        repeat (20) drive(1'b0, '0, '0, 1'b0);
        check("run_rst_no_result", FW'(n_res), FW'(n0));
        send_random(N);
        wait_res(n0 + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
